// File: rtl/accum_pkg.sv
// Shared types and default sizing for the banked accumulator write-back path.
package accum_pkg;

    localparam int SYS_COL    = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int ACCUM_SIZE = 4096;
    localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL;
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);
    localparam int CNT_WIDTH  = $clog2(ACCUM_ROW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [ACC_WIDTH-1:0]  data;
    } pipe_entry_t;

endpackage

// File: rtl/accum_col_pipe.sv
// One accumulator column: row counter, fixed 4-cycle read/add/write delay line
// and the adder that merges the bank read data with the incoming partial sum.
module accum_col_pipe
    import accum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  acc_mode,
    input  logic [CNT_WIDTH-1:0]  eff_rows,
    input  logic                  sa_vld,
    input  logic [ACC_WIDTH-1:0]  sa_data,
    input  logic [ACC_WIDTH-1:0]  rd_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ACC_WIDTH-1:0]  wr_data,
    output logic                  drop,
    output logic                  fin_next
);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 accept;
    pipe_entry_t          p0;
    pipe_entry_t          p1;
    pipe_entry_t          p2;

    assign accept   = run && sa_vld && (cnt < eff_rows);
    assign drop     = sa_vld && !accept;
    assign fin_next = accept ? ((cnt + CNT_WIDTH'(1)) == eff_rows) : (cnt == eff_rows);

    // Read data returns two cycles after rd_en, lining up with stage p2.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            p0      <= '0;
            p1      <= '0;
            p2      <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end

            p0.vld  <= accept;
            p0.addr <= cnt[ADDR_WIDTH-1:0];
            p0.data <= sa_data;
            p1      <= p0;
            p2      <= p1;

            rd_en   <= accept && acc_mode;
            rd_addr <= accept ? cnt[ADDR_WIDTH-1:0] : '0;

            wr_en   <= p2.vld;
            wr_addr <= p2.vld ? p2.addr : '0;
            if (!p2.vld) begin
                wr_data <= '0;
            end else if (acc_mode) begin
                wr_data <= rd_data + p2.data;
            end else begin
                wr_data <= p2.data;
            end
        end
    end

endmodule

// File: rtl/accum_mem_ctrl.sv
// Accumulator memory controller: per-tile FSM, row clamp, done/busy and sticky
// error for dropped partial sums; per-column datapaths live in accum_col_pipe.
module accum_mem_ctrl #(
    parameter int  SYS_COL    = accum_pkg::SYS_COL,
    parameter int  ACC_WIDTH  = accum_pkg::ACC_WIDTH,
    parameter int  DATA_WIDTH = 16,
    parameter int  ACCUM_SIZE = accum_pkg::ACCUM_SIZE,
    localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW),
    localparam int CNT_WIDTH  = $clog2(ACCUM_ROW) + 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic                                 accumulate,
    input  logic [DATA_WIDTH-1:0]                num_row,
    input  logic [SYS_COL-1:0]                   sa_vld,
    input  logic [SYS_COL-1:0][ACC_WIDTH-1:0]    sa_data,
    output logic [SYS_COL-1:0]                   mem_rd_en,
    output logic [SYS_COL-1:0][ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [SYS_COL-1:0][ACC_WIDTH-1:0]    mem_rd_data,
    output logic [SYS_COL-1:0]                   mem_wr_en,
    output logic [SYS_COL-1:0][ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [SYS_COL-1:0][ACC_WIDTH-1:0]    mem_wr_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    accum_pkg::state_t    state;
    logic [1:0]           drain_cnt;
    logic                 acc_mode;
    logic [CNT_WIDTH-1:0] eff_rows;
    logic [CNT_WIDTH-1:0] clamp_rows;
    logic                 start_ok;
    logic                 col_run;
    logic [SYS_COL-1:0]   col_drop;
    logic [SYS_COL-1:0]   col_fin;

    assign start_ok   = start && (state == accum_pkg::IDLE);
    assign col_run    = (state == accum_pkg::RUN);
    assign clamp_rows = (num_row > DATA_WIDTH'(ACCUM_ROW)) ? CNT_WIDTH'(ACCUM_ROW)
                                                           : CNT_WIDTH'(num_row);

    // DRAIN lasts exactly four cycles: the depth of the column delay line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= accum_pkg::IDLE;
            drain_cnt <= '0;
            acc_mode  <= 1'b0;
            eff_rows  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= (start_ok ? 1'b0 : err) | (|col_drop);
            case (state)
                accum_pkg::IDLE: begin
                    if (start) begin
                        acc_mode <= accumulate;
                        eff_rows <= clamp_rows;
                        busy     <= 1'b1;
                        state    <= (clamp_rows == '0) ? accum_pkg::FIN : accum_pkg::RUN;
                    end
                end
                accum_pkg::RUN: begin
                    if (&col_fin) begin
                        drain_cnt <= '0;
                        state     <= accum_pkg::DRAIN;
                    end
                end
                accum_pkg::DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd3) begin
                        state <= accum_pkg::FIN;
                    end
                end
                accum_pkg::FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= accum_pkg::IDLE;
                end
                default: begin
                    state <= accum_pkg::IDLE;
                end
            endcase
        end
    end

    for (genvar j = 0; j < SYS_COL; j++) begin : g_col
        accum_col_pipe u_col (
            .clk      (clk),
            .rstn     (rstn),
            .clear    (start_ok),
            .run      (col_run),
            .acc_mode (acc_mode),
            .eff_rows (eff_rows),
            .sa_vld   (sa_vld[j]),
            .sa_data  (sa_data[j]),
            .rd_data  (mem_rd_data[j]),
            .rd_en    (mem_rd_en[j]),
            .rd_addr  (mem_rd_addr[j]),
            .wr_en    (mem_wr_en[j]),
            .wr_addr  (mem_wr_addr[j]),
            .wr_data  (mem_wr_data[j]),
            .drop     (col_drop[j]),
            .fin_next (col_fin[j])
        );
    end

endmodule

// File: tb/tb_accum_mem_ctrl.sv
// Scoreboard bench for accum_mem_ctrl: stimulus pushes expected bank reads and
// writes from a per-bank reference image; an independent monitor pops and compares.
module tb_accum_mem_ctrl;

    localparam int SYS_COL    = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int DATA_WIDTH = 16;
    localparam int ACCUM_ROW  = 256;
    localparam int ADDR_WIDTH = 8;

    logic                               clk = 1'b0;
    logic                               rstn = 1'b0;
    logic                               start = 1'b0;
    logic                               accumulate = 1'b0;
    logic [DATA_WIDTH-1:0]              num_row = '0;
    logic [SYS_COL-1:0]                 sa_vld = '0;
    logic [SYS_COL-1:0][ACC_WIDTH-1:0]  sa_data = '0;
    logic [SYS_COL-1:0]                 mem_rd_en;
    logic [SYS_COL-1:0][ADDR_WIDTH-1:0] mem_rd_addr;
    logic [SYS_COL-1:0][ACC_WIDTH-1:0]  mem_rd_data;
    logic [SYS_COL-1:0][ACC_WIDTH-1:0]  rd_stage;
    logic [SYS_COL-1:0]                 mem_wr_en;
    logic [SYS_COL-1:0][ADDR_WIDTH-1:0] mem_wr_addr;
    logic [SYS_COL-1:0][ACC_WIDTH-1:0]  mem_wr_data;
    logic                               busy;
    logic                               done;
    logic                               err;

    typedef struct {
        int               addr;
        logic [31:0]      data;
        int               cyc;
    } exp_t;

    exp_t        wr_q [SYS_COL][$];
    exp_t        rd_q [SYS_COL][$];
    logic [31:0] ref_mem [SYS_COL][ACCUM_ROW];
    logic [31:0] ram [SYS_COL][ACCUM_ROW];
    logic        preload_en = 1'b0;
    logic [31:0] preload_val = '0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          done_count = 0;

    accum_mem_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .accumulate  (accumulate),
        .num_row     (num_row),
        .sa_vld      (sa_vld),
        .sa_data     (sa_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank RAM model: two-cycle read latency, garbage when not enabled.
    always @(posedge clk) begin
        for (int j = 0; j < SYS_COL; j++) begin
            if (preload_en) begin
                for (int a = 0; a < ACCUM_ROW; a++) ram[j][a] <= preload_val;
            end else if (mem_wr_en[j]) begin
                ram[j][mem_wr_addr[j]] <= mem_wr_data[j];
            end
            rd_stage[j]    <= mem_rd_en[j] ? ram[j][mem_rd_addr[j]] : $urandom;
            mem_rd_data[j] <= rd_stage[j];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every bank access the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        for (int j = 0; j < SYS_COL; j++) begin
            if (mem_wr_en[j]) begin
                if (wr_q[j].size() == 0) begin
                    checkOutput($sformatf("unexpected_wr_en[%0d]", j), 32'(mem_wr_en[j]), 32'd0);
                end else begin
                    e = wr_q[j].pop_front();
                    checkOutput($sformatf("wr_addr[%0d]", j), 32'(mem_wr_addr[j]), e.addr);
                    checkOutput($sformatf("wr_data[%0d]", j), mem_wr_data[j], e.data);
                    checkOutput($sformatf("wr_cycle[%0d]", j), cyc, e.cyc);
                end
            end
            if (mem_rd_en[j]) begin
                if (rd_q[j].size() == 0) begin
                    checkOutput($sformatf("unexpected_rd_en[%0d]", j), 32'(mem_rd_en[j]), 32'd0);
                end else begin
                    e = rd_q[j].pop_front();
                    checkOutput($sformatf("rd_addr[%0d]", j), 32'(mem_rd_addr[j]), e.addr);
                    checkOutput($sformatf("rd_cycle[%0d]", j), cyc, e.cyc);
                end
            end
        end
        if (done) done_count++;
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] v);
        nextCycle();
        preload_val = v;
        preload_en  = 1'b1;
        for (int j = 0; j < SYS_COL; j++)
            for (int a = 0; a < ACCUM_ROW; a++) ref_mem[j][a] = v;
        nextCycle();
        preload_en = 1'b0;
    endtask

    task automatic flushQueues();
        for (int j = 0; j < SYS_COL; j++) begin
            wr_q[j].delete();
            rd_q[j].delete();
        end
    endtask

    // One tile: schedule per-column valids, model acceptance, then check done/err.
    task automatic applyStimulus(input bit acc, input int nrow, input bit gaps,
                                 input bit rand_data, input logic [31:0] cval, input bit extra_col0);
        int          eff;
        int          cnt_m [SYS_COL];
        int          idx [SYS_COL];
        int          sched [SYS_COL][$];
        int          o;
        int          start_cyc;
        int          last_acc;
        int          exp_done;
        int          pend_total;
        bit          err_exp;
        bit          pending;
        bit          all_done;
        logic [31:0] d;
        logic [31:0] v;

        eff = (nrow > ACCUM_ROW) ? ACCUM_ROW : nrow;
        for (int j = 0; j < SYS_COL; j++) begin
            cnt_m[j] = 0;
            idx[j]   = 0;
            sched[j].delete();
            o = j;
            for (int r = 0; r < eff + ((extra_col0 && j == 0) ? 1 : 0); r++) begin
                sched[j].push_back(o);
                o += gaps ? 1 + $urandom_range(0, 2) : 1;
            end
        end
        err_exp  = 1'b0;
        last_acc = -1;

        nextCycle();
        start      = 1'b1;
        accumulate = acc;
        num_row    = DATA_WIDTH'(nrow);
        start_cyc  = cyc;
        checkOutput("busy_before_start", busy, 1'b0);
        nextCycle();
        start = 1'b0;

        for (int t = 0; t < 2000; t++) begin
            pending = 1'b0;
            for (int j = 0; j < SYS_COL; j++) begin
                sa_vld[j] = 1'b0;
                if (idx[j] < sched[j].size()) begin
                    pending = 1'b1;
                    if (sched[j][idx[j]] == t) begin
                        idx[j]++;
                        d = rand_data ? $urandom : cval;
                        sa_vld[j]  = 1'b1;
                        sa_data[j] = d;
                        if (cnt_m[j] < eff) begin
                            v = acc ? ref_mem[j][cnt_m[j]] + d : d;
                            ref_mem[j][cnt_m[j]] = v;
                            wr_q[j].push_back('{addr: cnt_m[j], data: v, cyc: cyc + 4});
                            if (acc) rd_q[j].push_back('{addr: cnt_m[j], data: 32'd0, cyc: cyc + 1});
                            cnt_m[j]++;
                        end else begin
                            err_exp = 1'b1;
                        end
                    end
                end
            end
            if (t == 0) checkOutput("busy_in_tile", busy, 1'b1);
            all_done = 1'b1;
            for (int j = 0; j < SYS_COL; j++) if (cnt_m[j] != eff) all_done = 1'b0;
            if (last_acc < 0 && eff > 0 && all_done) last_acc = cyc;
            if (!pending) break;
            nextCycle();
        end
        sa_vld = '0;

        exp_done = (eff == 0) ? start_cyc + 2 : last_acc + 6;
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (done) break;
        end
        checkOutput("done_cycle", done ? cyc : -1, exp_done);
        checkOutput("busy_at_done", busy, 1'b0);
        checkOutput("err_at_done", err, err_exp);
        pend_total = 0;
        for (int j = 0; j < SYS_COL; j++) pend_total += wr_q[j].size() + rd_q[j].size();
        checkOutput("pending_accesses", pend_total, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 1'b0);
    endtask

    task automatic idleDrop();
        nextCycle();
        sa_vld = SYS_COL'(1) << $urandom_range(0, SYS_COL - 1);
        sa_data[0] = $urandom;
        @(negedge clk);
        checkOutput("err_same_cycle_idle_drop", err, 1'b0);
        nextCycle();
        sa_vld = '0;
        @(negedge clk);
        checkOutput("err_after_idle_drop", err, 1'b1);
    endtask

    task automatic resetMidRun();
        int snap;
        nextCycle();
        start      = 1'b1;
        accumulate = 1'b1;
        num_row    = DATA_WIDTH'(5);
        nextCycle();
        start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < SYS_COL; j++) begin
                sa_vld[j]  = 1'b1;
                sa_data[j] = $urandom;
                rd_q[j].push_back('{addr: r, data: 32'd0, cyc: cyc + 1});
            end
            nextCycle();
        end
        sa_vld = '0;
        rstn   = 1'b0;
        #1;
        checkOutput("rd_en_in_reset", mem_rd_en, '0);
        checkOutput("wr_en_in_reset", mem_wr_en, '0);
        checkOutput("busy_in_reset", busy, 1'b0);
        checkOutput("done_in_reset", done, 1'b0);
        flushQueues();
        snap = done_count;
        repeat (3) nextCycle();
        rstn = 1'b1;
        repeat (8) nextCycle();
        checkOutput("no_done_after_abort", done_count - snap, 0);
        applyStimulus(1'b0, 7, 1'b1, 1'b1, 32'd0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        checkOutput("reset_rd_en", mem_rd_en, '0);
        checkOutput("reset_wr_en", mem_wr_en, '0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_err", err, 1'b0);
        for (int j = 0; j < SYS_COL; j++)
            for (int a = 0; a < ACCUM_ROW; a++) ref_mem[j][a] = '0;
        repeat (2) nextCycle();
        rstn = 1'b1;
        preload(32'd0);

        $display("[TB] overwrite, 3 rows, ideal skew");
        applyStimulus(1'b0, 3, 1'b0, 1'b1, 32'd0, 1'b0);

        $display("[TB] accumulate 100 + 5, then - 5");
        preload(32'd100);
        applyStimulus(1'b1, 4, 1'b0, 1'b0, 32'd5, 1'b0);
        applyStimulus(1'b1, 4, 1'b1, 1'b0, 32'hFFFF_FFFB, 1'b0);

        $display("[TB] accumulate wrap");
        preload(32'hFFFF_FFFF);
        applyStimulus(1'b1, 2, 1'b0, 1'b0, 32'd1, 1'b0);

        $display("[TB] clamp 300 rows, extra valid on column 0");
        applyStimulus(1'b0, 300, 1'b0, 1'b1, 32'd0, 1'b1);

        $display("[TB] zero rows and idle drop");
        applyStimulus(1'b1, 0, 1'b0, 1'b1, 32'd0, 1'b0);
        idleDrop();

        $display("[TB] random tiles");
        for (int n = 0; n < 4; n++)
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 24), 1'b1, 1'b1, 32'd0, 1'b0);

        $display("[TB] reset mid-run");
        resetMidRun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
